pm1_obuf: RTL and testbench
===========================

# pm1_obuf

Output capture buffer for the pm1 decoder. It samples the decoder's 13-bit output vector whenever the upstream control marks it valid and stores samples in a small FIFO. It presents them downstream under a valid/ready handshake. The decoder has no backpressure, so a sample that cannot be stored is dropped and flagged with a sticky overflow bit.

## Interface
Parameters:
- DEPTH, default 4: FIFO entries. Must be a power of two and at least 2.
- WIDTH, default 13: vector width. Always set to the package width constant.

Ports:
- clock  in  1: single clock; all state updates on its rising edge.
- reset  in  1: synchronous, active-high.
- in_valid  in  1: the decoder output is meaningful this cycle.
- in_vec  in  WIDTH: decoder outputs. Bit mapping: 0 pa0, 1 pb0, 2 pr, 3 pc0, 4 ps, 5 pd0, 6 pt, 7 pu, 8 pv, 9 pw, 10 px, 11 py, 12 pz.
- in_ready  out  1: informational only; a sample offered while low is dropped.
- out_valid  out  1: the head entry is available.
- out_vec  out  WIDTH: head entry; all zeros when out_valid=0.
- out_ready  in  1: the consumer accepts the head entry.
- count  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow  out  1: sticky drop flag.
- clear_ovf  in  1: clears overflow.

## Operation
- Pop happens when out_valid && out_ready.
- in_ready = (count < DEPTH) || out_ready. Two consequences:
  - When full, a pop and a push in the same cycle both succeed.
  - count is unchanged by a simultaneous push and pop.
- Push happens when in_valid && in_ready and the sample is not suppressed by the configured feature (see Configuration).
  - The sample is written at the write pointer.
  - Pointers wrap modulo DEPTH.
  - count updates as +1 for push only, −1 for pop only, and is unchanged for both or neither.
- Drop happens when in_valid && !in_ready.
  - The sample is discarded.
  - overflow is set on the next edge.
  - count and the pointers are unchanged.
- overflow update rule:
  - A set condition and clear_ovf in the same cycle leave overflow set; set wins.
  - clear_ovf alone clears it.
- Empty with pop requested: impossible, because out_valid=0.
- Full with no pop: every valid sample is dropped.
- Reset values on the edge where reset=1, taking effect in the following cycle:
  - count=0, both pointers=0, out_valid=0, out_vec=0, overflow=0, in_ready=1.
  - Storage contents are don't-care.
  - Reset overrides push, pop and clear_ovf in the same cycle.
  - Reset mid-operation discards all entries.

## Timing
- Push-to-visible latency is 1 cycle. A vector accepted on edge N appears on out_vec with out_valid=1 after edge N, with no fall-through.
- out_valid, count and overflow are registered.
- out_vec is a registered-pointer read of storage, gated by out_valid.
- in_ready is combinational from count and out_ready. This is the only combinational input-to-output path.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- PM1_OBUF_DEDUP_EN defined:
  - A last_vec register plus a last_ok flag hold the most recently pushed vector. Both are cleared by reset.
  - A valid sample equal to last_vec while last_ok=1 is suppressed.
  - A suppressed sample causes no push and no overflow, even when the FIFO is full.
  - Each successful push loads last_vec and sets last_ok.
- Undefined: every valid sample follows the push/drop rules above. No last_vec logic is instantiated.

## Structure
- Package pm1_pkg holds:
  - PM1_OUT_W = 13.
  - Bit-index constants PM1_PA0 … PM1_PZ, matching the mapping in Interface.
  - typedef pm1_out_t, a logic vector [PM1_OUT_W-1:0].
  - Default depth constant PM1_OBUF_DEPTH = 4.
- Sub-module pm1_obuf_ram: a DEPTH×WIDTH register array with one write port and one asynchronous read port, and no reset.
- Top level: pointers, count, handshake, overflow, and the optional dedup logic.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 and in_vec=0x1FFF.
  - Required: count=0, out_valid=0, out_vec=0, overflow=0, in_ready=1.
- Ordering:
  - With out_ready=0, push 0x0001, 0x0002, 0x0004 → count=3.
  - Then hold out_ready=1 → out_vec is 0x0001, 0x0002, 0x0004 on successive cycles, and out_valid=0 on the 4th cycle.
- Overflow:
  - With DEPTH=4, fill with 0x0010..0x0013, then offer 0x1FFF with out_ready=0.
  - Required: count stays 4, overflow=1, and a later drain yields 0x0010..0x0013 only.
  - Pulse clear_ovf together with another drop → overflow stays 1.
  - Pulse clear_ovf alone → overflow=0.
- Full push/pop:
  - With count=4 and out_ready=1, offer 0x0AAA → in_ready=1, count stays 4, overflow=0.
  - 0x0AAA emerges as the 4th pop.
- Dedup:
  - Offer 0x0155 on two consecutive cycles, then 0x0156.
  - With PM1_OBUF_DEDUP_EN → count=2.
  - Without it → count=3.
- Reset mid-operation:
  - With count=3, pulse reset → count=0 and out_valid=0 on the next cycle.
  - Under dedup, re-offering the last pushed vector is accepted (count=1).

Source files
------------

// File: rtl/pm1_pkg.sv
// pm1_pkg: shared constants and types for the pm1 decoder output path.
// Holds the decoder output width, the bit positions of each decoder output
// within the packed vector, and the default capture-buffer depth.
package pm1_pkg;

    // Width of the decoder output vector.
    localparam int unsigned PM1_OUT_W = 13;

    // Bit positions of the individual decoder outputs inside the vector.
    localparam int unsigned PM1_PA0 = 0;
    localparam int unsigned PM1_PB0 = 1;
    localparam int unsigned PM1_PR  = 2;
    localparam int unsigned PM1_PC0 = 3;
    localparam int unsigned PM1_PS  = 4;
    localparam int unsigned PM1_PD0 = 5;
    localparam int unsigned PM1_PT  = 6;
    localparam int unsigned PM1_PU  = 7;
    localparam int unsigned PM1_PV  = 8;
    localparam int unsigned PM1_PW  = 9;
    localparam int unsigned PM1_PX  = 10;
    localparam int unsigned PM1_PY  = 11;
    localparam int unsigned PM1_PZ  = 12;

    // Default number of entries in the output capture buffer.
    localparam int unsigned PM1_OBUF_DEPTH = 4;

    // One decoder output sample.
    typedef logic [PM1_OUT_W-1:0] pm1_out_t;

    // True when n is a power of two and at least 2; used to sanity-check DEPTH.
    function automatic bit pm1_depth_ok(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pm1_obuf_ram.sv
// pm1_obuf_ram: DEPTH x WIDTH storage for the output capture buffer.
// One synchronous write port, one asynchronous read port, no reset: the
// contents are only ever observed through entries the pointers mark valid.
module pm1_obuf_ram
    import pm1_pkg::*;
#(
    parameter int unsigned DEPTH = PM1_OBUF_DEPTH,
    parameter int unsigned WIDTH = PM1_OUT_W,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read of the head entry.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/pm1_obuf.sv
// pm1_obuf: output capture buffer for the pm1 decoder.
// Samples the decoder vector whenever in_valid is high, queues it in a small
// FIFO and hands it downstream under valid/ready. The decoder cannot be
// stalled, so a sample arriving with no room is dropped and recorded in a
// sticky overflow flag.
//
// Build option: define PM1_OBUF_DEDUP_EN to suppress samples identical to the
// most recently pushed one. Without it every valid sample is pushed or dropped.
module pm1_obuf
    import pm1_pkg::*;
#(
    parameter int unsigned DEPTH = PM1_OBUF_DEPTH,
    parameter int unsigned WIDTH = PM1_OUT_W,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vec,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_vec,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    // FIFO state.
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic          overflow_q, overflow_d;

    // Handshake decode.
    logic             suppress;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] rd_data;

`ifdef PM1_OBUF_DEDUP_EN
    // Most recently pushed vector and whether it is meaningful yet.
    logic [WIDTH-1:0] last_vec_q, last_vec_d;
    logic             last_ok_q, last_ok_d;

    // A repeat of the last pushed vector is neither stored nor counted as a drop.
    always_comb begin
        suppress = in_valid && last_ok_q && (in_vec == last_vec_q);
    end

    // Track the last pushed vector.
    always_comb begin
        last_vec_d = last_vec_q;
        last_ok_d  = last_ok_q;
        if (push) begin
            last_vec_d = in_vec;
            last_ok_d  = 1'b1;
        end
    end

    // Dedup registers, cleared by reset so the first sample after reset is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_vec_q <= '0;
            last_ok_q  <= 1'b0;
        end else begin
            last_vec_q <= last_vec_d;
            last_ok_q  <= last_ok_d;
        end
    end
`else
    // No dedup: nothing is ever suppressed.
    always_comb begin
        suppress = 1'b0;
    end
`endif

    // Ready whenever there is room or the head leaves this cycle, so a full
    // buffer still sustains one push and one pop per cycle.
    always_comb begin
        in_ready = (count_q < DepthC) || out_ready;
    end

    // Decode push, pop and drop for this cycle.
    always_comb begin
        pop  = out_valid_q && out_ready;
        push = in_valid && in_ready && !suppress;
        drop = in_valid && !in_ready && !suppress;
    end

    // Next-state for pointers, occupancy, head-valid and the sticky flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // Pointers are AW bits wide and DEPTH is a power of two, so the
        // increment wraps modulo DEPTH on its own.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A fresh drop wins over a simultaneous clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end

        out_valid_d = (count_d != '0);
    end

    // FIFO state registers; reset discards all queued entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    pm1_obuf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clock   (clock),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_vec),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Registered outputs; the head is forced to zero while nothing is valid.
    always_comb begin
        out_valid = out_valid_q;
        out_vec   = out_valid_q ? rd_data : '0;
        count     = count_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_pm1_obuf.sv
// tb_pm1_obuf: scoreboard bench for pm1_obuf. Stimulus pushes the expected
// vector into a queue whenever it offers a sample that must be stored; a
// monitor on the falling edge pops and compares every accepted head entry.
module tb_pm1_obuf;
    import pm1_pkg::*;

    localparam int unsigned DEPTH = PM1_OBUF_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           reset;
    logic           in_valid;
    pm1_out_t       in_vec;
    logic           in_ready;
    logic           out_valid;
    pm1_out_t       out_vec;
    logic           out_ready;
    logic [CW-1:0]  count;
    logic           overflow;
    logic           clear_ovf;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    pm1_out_t exp_q[$];

    pm1_obuf #(
        .DEPTH (DEPTH),
        .WIDTH (PM1_OUT_W)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_vec   (out_vec),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for a single cycle; expect it stored when keep is set.
    task automatic offer(input pm1_out_t v, input bit keep);
        in_valid = 1'b1;
        in_vec   = v;
        if (keep) exp_q.push_back(v);
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: compare the head whenever it is accepted on the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no entry", out_vec);
                end else begin
                    pm1_out_t e;
                    e = exp_q.pop_front();
                    if (out_vec !== e) begin
                        bad++;
                        $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_vec, e);
                    end
                end
            end else if (out_valid === 1'b0) begin
                check("idle_out_vec", int'(out_vec), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pm1_out_t last_v;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 13'h1FFF;
        out_ready = 1'b0;
        clear_ovf = 1'b0;

        // Reset held two cycles with a valid sample present.
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_vec   = '0;
        check("rst_count", int'(count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_vec", int'(out_vec), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_in_ready", int'(in_ready), 1);
        mon_en = 1'b1;

        // Ordering.
        offer(13'h0001, 1'b1);
        offer(13'h0002, 1'b1);
        offer(13'h0004, 1'b1);
        check("ord_count", int'(count), 3);
        check("ord_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        step();
        step();
        step();
        check("ord_empty_valid", int'(out_valid), 0);
        check("ord_empty_count", int'(count), 0);
        out_ready = 1'b0;

        // Overflow.
        for (int i = 0; i < 4; i++) offer(pm1_out_t'(13'h0010 + i), 1'b1);
        check("full_count", int'(count), 4);
        check("full_in_ready", int'(in_ready), 0);
        offer(13'h1FFF, 1'b0);
        check("ovf_count", int'(count), 4);
        check("ovf_set", int'(overflow), 1);
        clear_ovf = 1'b1;
        offer(13'h1FFF, 1'b0);
        clear_ovf = 1'b0;
        check("ovf_set_wins", int'(overflow), 1);
        check("ovf_count2", int'(count), 4);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Full with simultaneous push and pop.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 13'h0AAA;
        #1;
        check("fullpp_in_ready", int'(in_ready), 1);
        exp_q.push_back(13'h0AAA);
        step();
        in_valid = 1'b0;
        check("fullpp_count", int'(count), 4);
        check("fullpp_overflow", int'(overflow), 0);
        for (int i = 0; i < 4; i++) step();
        check("drain_count", int'(count), 0);
        check("drain_out_valid", int'(out_valid), 0);
        check("drain_scoreboard_left", exp_q.size(), 0);
        out_ready = 1'b0;

        // Dedup of back-to-back identical samples.
`ifdef PM1_OBUF_DEDUP_EN
        offer(13'h0155, 1'b1);
        offer(13'h0155, 1'b0);
        offer(13'h0156, 1'b1);
        check("dedup_count", int'(count), 2);
        offer(13'h0157, 1'b1);
        last_v = 13'h0157;
`else
        offer(13'h0155, 1'b1);
        offer(13'h0155, 1'b1);
        offer(13'h0156, 1'b1);
        check("dedup_count", int'(count), 3);
        last_v = 13'h0156;
`endif
        check("pre_reset_count", int'(count), 3);

        // Reset mid-operation discards everything.
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        check("midrst_count", int'(count), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_overflow", int'(overflow), 0);

        // Last pushed vector is accepted again after reset.
        offer(last_v, 1'b1);
        check("post_rst_count", int'(count), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("final_count", int'(count), 0);
        check("final_scoreboard_left", exp_q.size(), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
